// File: rtl/nn_sched_pkg.sv
// -----------------------------------------------------------------------------
// nn_sched_pkg
// Shared definitions for the MLP layer sequencer:
//   - sequencer state encoding
//   - default layer geometry and pipeline latencies
//   - BRAM address width
//   - weight-BRAM base address and layer-length helpers
// -----------------------------------------------------------------------------
package nn_sched_pkg;

  localparam int ADDR_W      = 11;

  localparam int N_IN_DEF    = 784;
  localparam int N_HID_DEF   = 28;
  localparam int N_HL_DEF    = 2;
  localparam int N_OUT_DEF   = 10;
  localparam int RD_LAT_DEF  = 1;
  localparam int MAC_LAT_DEF = 2;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_MAC,
    S_DRAIN,
    S_RESC,
    S_WB,
    S_ARGMAX,
    S_DONE
  } state_t;

  // Weight rows are packed layer after layer: the input layer owns the first
  // n_in words, every later layer owns n_hid words.
  function automatic logic [ADDR_W-1:0] layer_base(input logic [1:0] l,
                                                   input int n_in,
                                                   input int n_hid);
    if (l == 2'd0) begin
      return '0;
    end
    return ADDR_W'(n_in + (int'(l) - 1) * n_hid);
  endfunction

  // Number of MAC cycles a layer needs: its fan-in.
  function automatic logic [ADDR_W-1:0] layer_len(input logic [1:0] l,
                                                  input int n_in,
                                                  input int n_hid);
    return (l == 2'd0) ? ADDR_W'(n_in) : ADDR_W'(n_hid);
  endfunction

endpackage

// File: rtl/nn_layer_sched_argmax_unit.sv
// -----------------------------------------------------------------------------
// argmax_unit
// Running signed maximum with index register. The first enabled compare after
// a clear seeds the maximum unconditionally; afterwards a lane replaces the
// incumbent only when strictly greater, so ties keep the lowest lane index.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clear          forget the current maximum (next compare seeds)
//   en             compare lane/score this cycle
//   lane           index of the score presented
//   score          signed score of that lane
//   best_idx_next  winning index including this cycle's compare
// -----------------------------------------------------------------------------
module argmax_unit #(
  parameter int IDX_W   = 4,
  parameter int SCORE_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      en,
  input  logic [IDX_W-1:0]          lane,
  input  logic signed [SCORE_W-1:0] score,
  output logic [IDX_W-1:0]          best_idx_next
);

  logic signed [SCORE_W-1:0] max_reg;
  logic [IDX_W-1:0]          idx_reg;
  logic                      seeded_reg;
  logic                      take;

  assign take          = en && (!seeded_reg || (score > max_reg));
  // Exposed combinationally so the final lane's compare can be captured on
  // the same edge that leaves the argmax sweep.
  assign best_idx_next = take ? lane : idx_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_reg    <= '0;
      idx_reg    <= '0;
      seeded_reg <= 1'b0;
    end else if (clear) begin
      max_reg    <= '0;
      idx_reg    <= '0;
      seeded_reg <= 1'b0;
    end else if (take) begin
      max_reg    <= score;
      idx_reg    <= lane;
      seeded_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/nn_layer_sched.sv
// -----------------------------------------------------------------------------
// nn_layer_sched
// Top-level sequencer for the 28-lane MLP datapath. Loads one image into the
// input buffer, runs the hidden layers (writing their activations back into
// the input buffer), runs the output layer, then picks the winning class.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         begin a run (only honoured in IDLE)
//   in_valid      pixel beat offered; in_ready high only while loading
//   ip_we/ip_src  input-buffer write enable / source (0 pixel, 1 activation)
//   ip_wr_addr    input-buffer write address
//   ip_rd_addr    input-buffer read address (MAC phase)
//   wt_addr       weight BRAM address shared by all lanes
//   mac_rst       clear accumulators
//   mac_en        accumulate enable, aligned to BRAM read data
//   rescale       one-cycle requantize strobe
//   lane_sel      lane index for write-back and argmax
//   score_in      signed score of lane lane_sel
//   layer         current layer (N_HL = output layer)
//   busy          any state other than IDLE
//   done          one-cycle completion pulse
//   class_out     winning class, held until the next completion
// -----------------------------------------------------------------------------
module nn_layer_sched
  import nn_sched_pkg::*;
#(
  parameter int N_IN    = N_IN_DEF,
  parameter int N_HID   = N_HID_DEF,
  parameter int N_HL    = N_HL_DEF,
  parameter int N_OUT   = N_OUT_DEF,
  parameter int RD_LAT  = RD_LAT_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ip_we,
  output logic              ip_src,
  output logic [ADDR_W-1:0] ip_wr_addr,
  output logic [ADDR_W-1:0] ip_rd_addr,
  output logic [ADDR_W-1:0] wt_addr,
  output logic              mac_rst,
  output logic              mac_en,
  output logic              rescale,
  output logic [4:0]        lane_sel,
  input  logic signed [31:0] score_in,
  output logic [1:0]        layer,
  output logic              busy,
  output logic              done,
  output logic [3:0]        class_out
);

  localparam logic [ADDR_W-1:0] LOAD_LAST  = ADDR_W'(N_IN - 1);
  localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(RD_LAT + MAC_LAT - 1);
  localparam logic [ADDR_W-1:0] WB_LAST    = ADDR_W'(N_HID - 1);
  localparam logic [ADDR_W-1:0] AM_LAST    = ADDR_W'(N_OUT - 1);
  localparam logic [1:0]        OUT_LAYER  = 2'(N_HL);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [1:0]        layer_reg, layer_next;
  logic [3:0]        class_reg;
  logic [RD_LAT-1:0] mac_pipe_reg;

  logic [ADDR_W-1:0] mac_last;
  logic [ADDR_W-1:0] base_addr;
  logic              am_clear;
  logic              am_en;
  logic              class_load;
  logic [3:0]        am_idx_next;

  assign base_addr = layer_base(layer_reg, N_IN, N_HID);
  assign mac_last  = layer_len(layer_reg, N_IN, N_HID) - ADDR_W'(1);

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      layer_reg <= '0;
      class_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      layer_reg <= layer_next;
      if (class_load) begin
        class_reg <= am_idx_next;
      end
    end
  end

  // mac_en tracks "in MAC" delayed by the BRAM read latency, so accumulation
  // lines up with the read data rather than the address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_pipe_reg <= '0;
    end else begin
      mac_pipe_reg[0] <= (state_reg == S_MAC);
      for (int i = 1; i < RD_LAT; i++) begin
        mac_pipe_reg[i] <= mac_pipe_reg[i-1];
      end
    end
  end

  assign mac_en    = mac_pipe_reg[RD_LAT-1];
  assign class_out = class_reg;
  assign layer     = layer_reg;

  // ---------------------------------------------------------------------------
  // Next state and combinational strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    layer_next = layer_reg;
    in_ready   = 1'b0;
    ip_we      = 1'b0;
    ip_src     = 1'b0;
    ip_wr_addr = '0;
    ip_rd_addr = '0;
    wt_addr    = '0;
    mac_rst    = 1'b0;
    rescale    = 1'b0;
    lane_sel   = '0;
    done       = 1'b0;
    busy       = (state_reg != S_IDLE);
    am_clear   = 1'b0;
    am_en      = 1'b0;
    class_load = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
          cnt_next   = '0;
          layer_next = '0;
        end
      end

      S_LOAD: begin
        in_ready   = 1'b1;
        ip_wr_addr = cnt_reg;
        if (in_valid) begin
          ip_we = 1'b1;
          if (cnt_reg == LOAD_LAST) begin
            state_next = S_CLR;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + ADDR_W'(1);
          end
        end
      end

      S_CLR: begin
        mac_rst    = 1'b1;
        cnt_next   = '0;
        state_next = S_MAC;
      end

      S_MAC: begin
        ip_rd_addr = cnt_reg;
        wt_addr    = base_addr + cnt_reg;
        if (cnt_reg == mac_last) begin
          state_next = S_DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end

      S_DRAIN: begin
        if (cnt_reg == DRAIN_LAST) begin
          state_next = S_RESC;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end

      S_RESC: begin
        rescale  = 1'b1;
        cnt_next = '0;
        if (layer_reg == OUT_LAYER) begin
          am_clear   = 1'b1;
          state_next = S_ARGMAX;
        end else begin
          state_next = S_WB;
        end
      end

      S_WB: begin
        // Hidden activations overwrite the head of the input buffer, which
        // the next layer then reads as its fan-in.
        lane_sel   = cnt_reg[4:0];
        ip_we      = 1'b1;
        ip_src     = 1'b1;
        ip_wr_addr = cnt_reg;
        if (cnt_reg == WB_LAST) begin
          state_next = S_CLR;
          cnt_next   = '0;
          layer_next = layer_reg + 2'd1;
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end

      S_ARGMAX: begin
        lane_sel = cnt_reg[4:0];
        am_en    = 1'b1;
        if (cnt_reg == AM_LAST) begin
          class_load = 1'b1;
          state_next = S_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end

      S_DONE: begin
        done       = 1'b1;
        layer_next = '0;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  argmax_unit #(
    .IDX_W   (4),
    .SCORE_W (32)
  ) u_argmax (
    .clk           (clk),
    .rst           (rst),
    .clear         (am_clear),
    .en            (am_en),
    .lane          (cnt_reg[3:0]),
    .score         (score_in),
    .best_idx_next (am_idx_next)
  );

endmodule
